// File: rtl/usb_line_pkg.sv
// Shared types and helpers for the USB transmit line encoder.
//   line_state_t : J / K / SE0 symbol driven on the bus
//   line_pins_t  : packed {d_plus, d_minus} pin pair
//   tx_state_t   : encoder FSM state
//   MAX_ONES     : run of 1s after which a stuffed 0 is inserted
package usb_line_pkg;

  localparam int unsigned MAX_ONES = 6;
  localparam int unsigned ONES_W   = 3;

  typedef enum logic [1:0] {
    LINE_J   = 2'd0,
    LINE_K   = 2'd1,
    LINE_SE0 = 2'd2
  } line_state_t;

  typedef struct packed {
    logic d_plus;
    logic d_minus;
  } line_pins_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_EOP_SE0 = 2'd2,
    ST_EOP_J   = 2'd3
  } tx_state_t;

  // Bus symbol to pin levels: J={1,0}, K={0,1}, SE0={0,0}.
  function automatic line_pins_t line_to_pins(input line_state_t l);
    line_pins_t p;
    p = '{d_plus: 1'b1, d_minus: 1'b0};
    case (l)
      LINE_K:   p = '{d_plus: 1'b0, d_minus: 1'b1};
      LINE_SE0: p = '{d_plus: 1'b0, d_minus: 1'b0};
      default:  p = '{d_plus: 1'b1, d_minus: 1'b0};
    endcase
    return p;
  endfunction

  // NRZI transition used for a data 0 (and for a stuffed bit).
  function automatic line_state_t nrzi_toggle(input line_state_t l);
    return (l == LINE_K) ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period timer: modulo-CLKS_PER_BIT counter.
//   clk, n_rst : clock, async active-low reset
//   clr        : force count to 0 (held in idle, pulsed on state change)
//   en         : count enable
//   bit_end    : high in the last clock of each bit period while enabled
module usb_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned     CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count 0..CLKS_PER_BIT-1 and wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign bit_end = en && (cnt_q == LAST);

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit timing, bit stuffing, NRZI and EOP.
// Pulls serial bits from the upstream shifter and drives D+/D-.
//   clk, n_rst   : clock, async active-low reset
//   tx_active    : packet in progress (SYNC load until EOP request)
//   tx_bit       : current serial data bit from the shifter
//   eop          : one-cycle end-of-packet request
//   shift_strobe : combinational; tx_bit consumed this cycle
//   eop_done     : combinational one-cycle pulse at the end of the EOP J bit
//   busy         : encoder not idle
//   d_plus/d_minus : registered line outputs (J when idle)
//   tx_oe        : transceiver output enable, only with USB_TX_OE_EN defined
module usb_tx_line_encoder
  import usb_line_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tx_active,
  input  logic tx_bit,
  input  logic eop,
  output logic shift_strobe,
  output logic eop_done,
  output logic busy,
  output logic d_plus,
  output logic d_minus
`ifdef USB_TX_OE_EN
  ,
  output logic tx_oe
`endif
);

  localparam int unsigned       SE0_W    = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
  localparam logic [SE0_W-1:0]  SE0_LAST = SE0_W'(EOP_SE0_BITS - 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(MAX_ONES);

  tx_state_t         state_q, state_d;
  line_state_t       line_q, line_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [SE0_W-1:0]  se0_q, se0_d;
  logic              eop_pend_q, eop_pend_d;
  logic              bit_end;
  logic              timer_clr;
  logic              timer_en;
  line_pins_t        pins_d;

  usb_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .bit_end (bit_end)
  );

  // Next-state and strobe logic.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    ones_d       = ones_q;
    se0_d        = se0_q;
    eop_pend_d   = eop_pend_q;
    shift_strobe = 1'b0;
    eop_done     = 1'b0;

    if (eop && (state_q != ST_IDLE)) begin
      eop_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        line_d     = LINE_J;
        ones_d     = '0;
        se0_d      = '0;
        eop_pend_d = 1'b0;
        if (tx_active) begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        // tx_active may fall together with the eop request, so a
        // same-cycle eop also keeps the packet alive.
        if (!tx_active && !eop_pend_q && !eop) begin
          state_d    = ST_IDLE;
          line_d     = LINE_J;
          ones_d     = '0;
          eop_pend_d = 1'b0;
        end else if (bit_end) begin
          if (ones_q == ONES_MAX) begin
            // Stuffed 0: the shifter holds tx_bit for the next period.
            line_d = nrzi_toggle(line_q);
            ones_d = '0;
          end else if (eop_pend_q) begin
            state_d    = ST_EOP_SE0;
            line_d     = LINE_SE0;
            se0_d      = '0;
            eop_pend_d = 1'b0;
          end else begin
            shift_strobe = 1'b1;
            if (tx_bit) begin
              ones_d = ones_q + ONES_W'(1);
            end else begin
              line_d = nrzi_toggle(line_q);
              ones_d = '0;
            end
          end
        end
      end

      ST_EOP_SE0: begin
        if (bit_end) begin
          if (se0_q == SE0_LAST) begin
            state_d = ST_EOP_J;
            line_d  = LINE_J;
            se0_d   = '0;
          end else begin
            se0_d = se0_q + SE0_W'(1);
          end
        end
      end

      ST_EOP_J: begin
        if (bit_end) begin
          eop_done   = 1'b1;
          state_d    = ST_IDLE;
          ones_d     = '0;
          eop_pend_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        line_d  = LINE_J;
      end
    endcase

    // Timer restarts on every state entry and stays cleared in idle.
    timer_en  = (state_q != ST_IDLE);
    timer_clr = (state_q == ST_IDLE) || (state_d != state_q);
  end

  assign pins_d = line_to_pins(line_d);

  // State and registered line outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      line_q     <= LINE_J;
      ones_q     <= '0;
      se0_q      <= '0;
      eop_pend_q <= 1'b0;
      d_plus     <= 1'b1;
      d_minus    <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      ones_q     <= ones_d;
      se0_q      <= se0_d;
      eop_pend_q <= eop_pend_d;
      d_plus     <= pins_d.d_plus;
      d_minus    <= pins_d.d_minus;
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef USB_TX_OE_EN
  // Output enable follows the packet: set on ACTIVE entry, cleared on return to idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_oe <= 1'b0;
    end else begin
      tx_oe <= (state_d != ST_IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Self-checking bench for usb_tx_line_encoder (CLKS_PER_BIT=8, EOP_SE0_BITS=2).
// Observed vector per cycle: {d_plus, d_minus, shift_strobe, eop_done, busy}.
module tb_usb_tx_line_encoder;

  localparam int CPB = 8;
  localparam logic [4:0] IDLE_V = 5'b10000;

  logic clk = 1'b0;
  logic n_rst;
  logic tx_active;
  logic tx_bit;
  logic eop;
  logic shift_strobe;
  logic eop_done;
  logic busy;
  logic d_plus;
  logic d_minus;
`ifdef USB_TX_OE_EN
  logic tx_oe;
`endif

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q[$];
  logic [4:0] obs;

  assign obs = {d_plus, d_minus, shift_strobe, eop_done, busy};

  usb_tx_line_encoder #(
    .CLKS_PER_BIT (8),
    .EOP_SE0_BITS (2)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_active    (tx_active),
    .tx_bit       (tx_bit),
    .eop          (eop),
    .shift_strobe (shift_strobe),
    .eop_done     (eop_done),
    .busy         (busy),
    .d_plus       (d_plus),
    .d_minus      (d_minus)
`ifdef USB_TX_OE_EN
    ,
    .tx_oe        (tx_oe)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // One packet. lvl[k]=1 means the bit period after decision k shows K (else J);
  // strb[k]=1 means decision k consumes a data bit. Non-abort packets end with
  // two SE0 periods, one J period and eop_done; aborts drop tx_active at drop_cyc.
  task automatic run_packet(input string name, input int nper, input logic [15:0] lvl,
                            input logic [15:0] strb, input logic [15:0] data,
                            input int eop_cyc, input int drop_cyc, input bit abort);
    int total;
    int idx;
    bit adv;
    logic [4:0] e;
    total = abort ? (drop_cyc + 1) : (CPB * (nper + 4));

    @(negedge clk);
    idx       = 0;
    adv       = 1'b0;
    tx_active = 1'b1;
    tx_bit    = data[0];
    eop       = 1'b0;

    // Expected trace, one entry per cycle from ACTIVE entry plus one idle cycle.
    for (int c = 0; c < total; c++) begin
      logic [1:0] ln;
      logic       st;
      if (c < CPB)                    ln = 2'b10;
      else if (c < CPB * (nper + 1))  ln = lvl[c / CPB - 1] ? 2'b01 : 2'b10;
      else if (c < CPB * (nper + 3))  ln = 2'b00;
      else                            ln = 2'b10;
      st = ((c % CPB) == CPB - 1) && ((c / CPB) < nper) && strb[c / CPB];
      exp_q.push_back({ln, st, (!abort && (c == total - 1)), 1'b1});
    end
    exp_q.push_back(IDLE_V);

    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        e = 5'b11111;
      end else begin
        e = exp_q.pop_front();
      end
      check_val($sformatf("%s_c%0d", name, c), obs, e);
      // Shifter advances after the edge that consumed the strobed bit.
      if (adv && (idx < 15)) begin
        idx++;
        tx_bit = data[idx];
      end
      adv       = shift_strobe;
      eop       = (c == eop_cyc);
      tx_active = (c < drop_cyc);
    end
    tx_active = 1'b0;
    eop       = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    n_rst     = 1'b0;
    tx_active = 1'b0;
    tx_bit    = 1'b0;
    eop       = 1'b0;

    // Reset values.
    repeat (3) begin
      @(negedge clk);
      check_val("reset", obs, IDLE_V);
    end
    n_rst = 1'b1;

    // Idle holds J; an eop in idle must be ignored.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_val($sformatf("idle_c%0d", c), obs, IDLE_V);
      eop = (c == 50);
    end
    eop = 1'b0;

    // SYNC 0x80 then a 0; eop lands on a bit_end and waits one more period.
    run_packet("sync", 9, 16'h00D5, 16'h01FF, 16'h0080, 71, 72, 1'b0);

    // Twelve 1s: stuff after six, then eop during the 6th 1 of the next run.
    run_packet("stuff", 14, 16'h1FC0, 16'h1FBF, 16'h0FFF, 106, 107, 1'b0);

    // Abort mid-byte with four 1s counted.
    run_packet("abort", 5, 16'h001F, 16'h001F, 16'h001E, -1, 43, 1'b1);

    // New packet must stuff after exactly six fresh 1s.
    run_packet("restart", 8, 16'h00C0, 16'h00BF, 16'h007F, 66, 67, 1'b0);

    // Reset during EOP_SE0.
    @(negedge clk);
    tx_active = 1'b1;
    tx_bit    = 1'b0;
    repeat (10) @(negedge clk);
    eop = 1'b1;
    @(negedge clk);
    eop       = 1'b0;
    tx_active = 1'b0;
    repeat (10) @(negedge clk);
    check_val("mrst_se0", obs, 5'b00001);
    #1 n_rst = 1'b0;
    #1 check_val("mrst_async", obs, IDLE_V);
    repeat (3) begin
      @(negedge clk);
      check_val("mrst_hold", obs, IDLE_V);
    end
    n_rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check_val($sformatf("mrst_idle_c%0d", c), obs, IDLE_V);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
